// File: rtl/mem_responder_pkg.sv
// Shared types and constants for the byte-wide memory responder.
package mem_resp_pkg;

    localparam int LAT_W = 8;
    localparam logic [7:0] OOR_RDATA = 8'h00;

    typedef enum logic [1:0] {
        IDLE,
        WR_WAIT,
        RD_WAIT
    } state_t;

endpackage

// File: rtl/mem_responder_if.sv
// Memory request interface: the initiator drives requests, the responder drives status and read data.
interface mem_responder_if;

    logic [31:0] addr;
    logic        wr_req;
    logic        rd_req;
    logic [7:0]  wdata;
    logic [7:0]  rdata;
    logic        busy;
    logic        rd_rdy;
    logic        prot_err;

    modport master (
        output addr, wr_req, rd_req, wdata,
        input  rdata, busy, rd_rdy, prot_err
    );

    modport slave (
        input  addr, wr_req, rd_req, wdata,
        output rdata, busy, rd_rdy, prot_err
    );

endinterface

// File: rtl/mem_resp_array.sv
// Single-port byte array: synchronous write, combinational read of the same address.
module mem_resp_array #(
    parameter int AW = 10
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [7:0]    wdata,
    output logic [7:0]    rdata
);

    logic [7:0] mem [2**AW];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/mem_responder.sv
// Memory responder with programmable write/read latency, range checking and protocol-error reporting.
module mem_responder
    import mem_resp_pkg::*;
#(
    parameter int AW     = 10,
    parameter int WR_LAT = 3,
    parameter int RD_LAT = 4
) (
    input  logic            clk,
    input  logic            reset,
    mem_responder_if.slave  bus
);

    state_t             state_reg, state_next;
    logic [LAT_W-1:0]   cnt_reg, cnt_next;
    logic               busy_reg, busy_next;
    logic               rd_rdy_reg, rd_rdy_next;
    logic               prot_err_reg, prot_err_next;
    logic [7:0]         rdata_reg, rdata_next;
    logic [AW-1:0]      addr_reg;
    logic [7:0]         wdata_reg;
    logic               oor_reg;
    logic               acc;
    logic               commit;
    logic [7:0]         array_rdata;

    assign acc = (bus.wr_req | bus.rd_req) & ~busy_reg;

    always_comb begin
        state_next    = state_reg;
        cnt_next      = cnt_reg;
        busy_next     = busy_reg;
        rd_rdy_next   = 1'b0;
        prot_err_next = 1'b0;
        rdata_next    = rdata_reg;
        commit        = 1'b0;
        case (state_reg)
            IDLE: begin
                if (acc) begin
                    busy_next = 1'b1;
                    if (bus.wr_req) begin
                        // A write wins over a simultaneous read; the dropped read is flagged.
                        state_next    = WR_WAIT;
                        cnt_next      = LAT_W'(WR_LAT - 1);
                        prot_err_next = bus.rd_req;
                    end else begin
                        state_next = RD_WAIT;
                        cnt_next   = LAT_W'(RD_LAT - 1);
                    end
                end
            end
            WR_WAIT: begin
                if (cnt_reg == '0) begin
                    commit        = ~oor_reg;
                    prot_err_next = oor_reg;
                    busy_next     = 1'b0;
                    state_next    = IDLE;
                end else begin
                    cnt_next = cnt_reg - LAT_W'(1);
                end
            end
            RD_WAIT: begin
                if (cnt_reg == '0) begin
                    rdata_next    = oor_reg ? OOR_RDATA : array_rdata;
                    rd_rdy_next   = 1'b1;
                    prot_err_next = oor_reg;
                    busy_next     = 1'b0;
                    state_next    = IDLE;
                end else begin
                    cnt_next = cnt_reg - LAT_W'(1);
                end
            end
            default: begin
                state_next = IDLE;
                busy_next  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg    <= IDLE;
            cnt_reg      <= '0;
            busy_reg     <= 1'b0;
            rd_rdy_reg   <= 1'b0;
            prot_err_reg <= 1'b0;
            rdata_reg    <= 8'h00;
        end else begin
            state_reg    <= state_next;
            cnt_reg      <= cnt_next;
            busy_reg     <= busy_next;
            rd_rdy_reg   <= rd_rdy_next;
            prot_err_reg <= prot_err_next;
            rdata_reg    <= rdata_next;
        end
    end

    // Request latches: captured once per accepted request, later input changes are ignored.
    always_ff @(posedge clk) begin
        if (acc) begin
            addr_reg  <= bus.addr[AW-1:0];
            oor_reg   <= |bus.addr[31:AW];
            wdata_reg <= bus.wdata;
        end
    end

    mem_resp_array #(
        .AW (AW)
    ) u_array (
        .clk   (clk),
        .we    (commit & reset),
        .addr  (addr_reg),
        .wdata (wdata_reg),
        .rdata (array_rdata)
    );

    assign bus.busy     = busy_reg;
    assign bus.rd_rdy   = rd_rdy_reg;
    assign bus.prot_err = prot_err_reg;
    assign bus.rdata    = rdata_reg;

endmodule

// File: tb/tb_mem_responder.sv
// Randomized self-checking bench for mem_responder against a cycle-profile reference model.
module tb_mem_responder;

    localparam int AW     = 10;
    localparam int WR_LAT = 3;
    localparam int RD_LAT = 4;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    mem_responder_if bus ();

    mem_responder #(
        .AW     (AW),
        .WR_LAT (WR_LAT),
        .RD_LAT (RD_LAT)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    logic [7:0]  model [int];
    logic [31:0] written_q [$];

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Drives one request and checks busy/rd_rdy/prot_err/rdata every cycle up to completion.
    task automatic do_op(input bit wr, input bit rd, input logic [31:0] a,
                         input logic [7:0] d, input bit hold);
        bit         oor;
        bit         rd_only;
        bit         known;
        int         lat;
        logic [7:0] exp_rd;
        oor     = (a >> AW) != 0;
        rd_only = rd && !wr;
        lat     = wr ? WR_LAT : RD_LAT;
        known   = 1'b1;
        exp_rd  = 8'h00;
        if (!oor) begin
            if (model.exists(int'(a))) exp_rd = model[int'(a)];
            else known = 1'b0;
        end
        $display("op wr=%0d rd=%0d addr=%08h wdata=%02h hold=%0d", wr, rd, a, d, hold);
        bus.addr   = a;
        bus.wdata  = d;
        bus.wr_req = wr;
        bus.rd_req = rd;
        @(posedge clk);
        for (int k = 0; k <= lat; k++) begin
            @(negedge clk);
            check_val("busy", {31'b0, bus.busy}, {31'b0, (k < lat)});
            if (k == 0) begin
                if (!hold) begin
                    bus.wr_req = 1'b0;
                    bus.rd_req = 1'b0;
                end
                bus.addr  = $urandom;
                bus.wdata = 8'($urandom);
            end
            check_val("rd_rdy", {31'b0, bus.rd_rdy}, {31'b0, (rd_only && k == lat)});
            check_val("prot_err", {31'b0, bus.prot_err},
                      {31'b0, ((wr && rd && k == 0) || (oor && k == lat))});
            if (rd_only && k == lat && known)
                check_val("rdata", {24'b0, bus.rdata}, {24'b0, exp_rd});
        end
        if (wr && !oor) begin
            if (!model.exists(int'(a))) written_q.push_back(a);
            model[int'(a)] = d;
        end
    endtask

    initial begin
        logic [31:0] a;
        logic [7:0]  d;
        int          r;

        reset      = 1'b0;
        bus.addr   = '0;
        bus.wdata  = '0;
        bus.wr_req = 1'b0;
        bus.rd_req = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_val("rst_busy", {31'b0, bus.busy}, 32'h0);
        check_val("rst_rd_rdy", {31'b0, bus.rd_rdy}, 32'h0);
        check_val("rst_prot_err", {31'b0, bus.prot_err}, 32'h0);
        check_val("rst_rdata", {24'b0, bus.rdata}, 32'h0);
        reset = 1'b1;

        do_op(1, 0, 32'h10, 8'hA5, 0);
        do_op(0, 1, 32'h10, 8'h00, 0);

        for (int i = 0; i < 4; i++) do_op(1, 0, 32'(i), 8'(i + 1), i < 3);
        for (int i = 0; i < 4; i++) do_op(0, 1, 32'(i), 8'h00, 0);

        do_op(1, 1, 32'h20, 8'h3C, 0);
        do_op(0, 1, 32'h20, 8'h00, 0);

        do_op(1, 0, 32'h0000_0400, 8'hFF, 0);
        do_op(0, 1, 32'h0000_0400, 8'h00, 0);
        do_op(0, 1, 32'h0, 8'h00, 0);

        // Reset one cycle after accepting a write must abandon the commit.
        do_op(1, 0, 32'h5, 8'h11, 0);
        $display("op wr=1 rd=0 addr=00000005 wdata=77 reset-after-accept");
        bus.addr   = 32'h5;
        bus.wdata  = 8'h77;
        bus.wr_req = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_val("mid_accept_busy", {31'b0, bus.busy}, 32'h1);
        bus.wr_req = 1'b0;
        reset      = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_val("mid_rst_busy", {31'b0, bus.busy}, 32'h0);
        check_val("mid_rst_rd_rdy", {31'b0, bus.rd_rdy}, 32'h0);
        check_val("mid_rst_prot_err", {31'b0, bus.prot_err}, 32'h0);
        check_val("mid_rst_rdata", {24'b0, bus.rdata}, 32'h0);
        reset = 1'b1;
        @(negedge clk);
        do_op(0, 1, 32'h5, 8'h00, 0);

        for (int n = 0; n < 60; n++) begin
            r = $urandom_range(0, 7);
            d = 8'($urandom);
            if (r < 3) begin
                a = 32'($urandom_range(0, 63));
                do_op(1, 0, a, d, 0);
            end else if (r == 3) begin
                a = $urandom | (32'h1 << AW);
                do_op(1, 0, a, d, 0);
            end else if (r == 4) begin
                a = 32'($urandom_range(0, 2**AW - 1));
                do_op(1, 1, a, d, 0);
            end else if (r == 5) begin
                a = $urandom | (32'h1 << AW);
                do_op(0, 1, a, d, 0);
            end else begin
                a = written_q[$urandom_range(0, written_q.size() - 1)];
                do_op(0, 1, a, d, 0);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
